// File: rtl/tmds_word_aligner.sv
// TMDS receive word aligner: finds the 10-bit symbol boundary from control tokens, then decodes 10b->8b.
// Optional lock statistics (relock_count, offset_at_lock) are built when TMDS_ALIGN_STATS_EN is defined.
module tmds_word_aligner #(
  parameter int LOCK_TOKENS   = 8,
  parameter int SEARCH_WINDOW = 4096,
  parameter int LOSS_TIMEOUT  = 65536
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic [9:0]  raw_word,
  input  logic        force_search,
  output logic        locked,
  output logic [3:0]  bit_offset,
  output logic        de,
  output logic [1:0]  ctrl,
  output logic [7:0]  data
`ifdef TMDS_ALIGN_STATS_EN
  ,
  output logic [15:0] relock_count,
  output logic [3:0]  offset_at_lock
`endif
);

  localparam int DWELL_W = $clog2(SEARCH_WINDOW);
  localparam int HIT_W   = $clog2(LOCK_TOKENS + 1);
  localparam int IDLE_W  = $clog2(LOSS_TIMEOUT);

  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(SEARCH_WINDOW - 1);
  localparam logic [HIT_W-1:0]   HIT_LAST  = HIT_W'(LOCK_TOKENS - 1);
  localparam logic [IDLE_W-1:0]  IDLE_MAX  = IDLE_W'(LOSS_TIMEOUT - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t              r_state;
  logic [3:0]          r_offset;
  logic [DWELL_W-1:0]  r_dwell;
  logic [HIT_W-1:0]    r_hits;
  logic [IDLE_W-1:0]   r_idle;
  logic [9:0]          r_prev;
  logic [9:0]          r_word;
  logic                r_locked;
  logic                r_de;
  logic [1:0]          r_ctrl;
  logic [7:0]          r_data;

  logic [18:0]         w_window;
  logic [9:0]          w_cand;
  logic                w_isToken;
  logic [1:0]          w_tokCtrl;
  logic [7:0]          w_q;
  logic [7:0]          w_data;
  logic [3:0]          w_nextOffset;

  // Offsets only reach 9, so the top bit of the newest word is never part of a candidate.
  assign w_window = {raw_word[8:0], r_prev};

  always_comb begin
    w_cand = w_window[9:0];
    for (int k = 1; k < 10; k++) begin
      if (r_offset == 4'(k)) w_cand = w_window[k +: 10];
    end
  end

  always_comb begin
    w_isToken = 1'b1;
    w_tokCtrl = 2'b00;
    case (r_word)
      10'b1101010100: w_tokCtrl = 2'b00;
      10'b0010101011: w_tokCtrl = 2'b01;
      10'b0101010100: w_tokCtrl = 2'b10;
      10'b1010101011: w_tokCtrl = 2'b11;
      default:        w_isToken = 1'b0;
    endcase
  end

  always_comb begin
    w_q       = r_word[9] ? ~r_word[7:0] : r_word[7:0];
    w_data    = 8'h00;
    w_data[0] = w_q[0];
    for (int i = 1; i < 8; i++) begin
      w_data[i] = r_word[8] ? (w_q[i] ^ w_q[i-1]) : ~(w_q[i] ^ w_q[i-1]);
    end
  end

  assign w_nextOffset = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;

  always_ff @(posedge clk_pixel or negedge reset) begin
    if (!reset) begin
      r_prev <= '0;
      r_word <= '0;
    end else begin
      r_prev <= raw_word;
      r_word <= w_cand;
    end
  end

  // force_search beats lock and timeout; within SEARCH, lock beats dwell expiry.
  always_ff @(posedge clk_pixel or negedge reset) begin
    if (!reset) begin
      r_state  <= SEARCH;
      r_offset <= 4'd0;
      r_dwell  <= '0;
      r_hits   <= '0;
      r_idle   <= '0;
`ifdef TMDS_ALIGN_STATS_EN
      relock_count   <= 16'h0000;
      offset_at_lock <= 4'd0;
`endif
    end else begin
      case (r_state)
        SEARCH: begin
          if (force_search) begin
            r_offset <= w_nextOffset;
            r_dwell  <= '0;
            r_hits   <= '0;
          end else if (w_isToken && (r_hits == HIT_LAST)) begin
            r_state <= LOCKED;
            r_dwell <= '0;
            r_hits  <= '0;
            r_idle  <= '0;
`ifdef TMDS_ALIGN_STATS_EN
            offset_at_lock <= r_offset;
`endif
          end else if (r_dwell == DWELL_MAX) begin
            r_offset <= w_nextOffset;
            r_dwell  <= '0;
            r_hits   <= '0;
          end else begin
            r_dwell <= r_dwell + DWELL_W'(1);
            r_hits  <= w_isToken ? r_hits + HIT_W'(1) : '0;
          end
        end
        LOCKED: begin
          if (force_search || (!w_isToken && (r_idle == IDLE_MAX))) begin
            r_state <= SEARCH;
            if (force_search) r_offset <= w_nextOffset;
            r_dwell <= '0;
            r_hits  <= '0;
            r_idle  <= '0;
`ifdef TMDS_ALIGN_STATS_EN
            if (relock_count != 16'hFFFF) relock_count <= relock_count + 16'd1;
`endif
          end else if (w_isToken) begin
            r_idle <= '0;
          end else begin
            r_idle <= r_idle + IDLE_W'(1);
          end
        end
        default: r_state <= SEARCH;
      endcase
    end
  end

  // Outputs trail the FSM by one cycle and stay quiet until the boundary is held.
  always_ff @(posedge clk_pixel or negedge reset) begin
    if (!reset) begin
      r_locked <= 1'b0;
      r_de     <= 1'b0;
      r_ctrl   <= 2'b00;
      r_data   <= 8'h00;
    end else begin
      r_locked <= (r_state == LOCKED);
      if (r_state != LOCKED) begin
        r_de   <= 1'b0;
        r_ctrl <= 2'b00;
        r_data <= 8'h00;
      end else if (w_isToken) begin
        r_de   <= 1'b0;
        r_ctrl <= w_tokCtrl;
        r_data <= 8'h00;
      end else begin
        r_de   <= 1'b1;
        r_data <= w_data;
      end
    end
  end

  assign locked     = r_locked;
  assign bit_offset = r_offset;
  assign de         = r_de;
  assign ctrl       = r_ctrl;
  assign data       = r_data;

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Directed bench for tmds_word_aligner: serial token stream at a chosen bit shift, decode vectors,
// loss timeout, force_search and asynchronous reset; stats ports are checked when TMDS_ALIGN_STATS_EN is set.
module tb_tmds_word_aligner;

  localparam logic [9:0] T0 = 10'b1101010100;
  localparam logic [9:0] T1 = 10'b0010101011;
  localparam logic [9:0] T2 = 10'b0101010100;
  localparam logic [9:0] T3 = 10'b1010101011;
  localparam int LOSS = 65536;

  logic       clk_pixel = 1'b0;
  logic       reset;
  logic [9:0] raw_word;
  logic       force_search;
  logic       locked;
  logic [3:0] bit_offset;
  logic       de;
  logic [1:0] ctrl;
  logic [7:0] data;
`ifdef TMDS_ALIGN_STATS_EN
  logic [15:0] relock_count;
  logic [3:0]  offset_at_lock;
`endif

  int vecCount  = 0;
  int missCount = 0;
  int cyc       = 0;
  int shift     = 3;
  logic [9:0]  lastSym = T0;
  logic [19:0] pair;

  logic [9:0]  seqSym [16];
  logic [10:0] seqExp [16];

  tmds_word_aligner #(
    .LOCK_TOKENS(8),
    .SEARCH_WINDOW(64),
    .LOSS_TIMEOUT(LOSS)
  ) dut (
    .clk_pixel(clk_pixel),
    .reset(reset),
    .raw_word(raw_word),
    .force_search(force_search),
    .locked(locked),
    .bit_offset(bit_offset),
    .de(de),
    .ctrl(ctrl),
    .data(data)
`ifdef TMDS_ALIGN_STATS_EN
    ,
    .relock_count(relock_count),
    .offset_at_lock(offset_at_lock)
`endif
  );

  always #5 clk_pixel = ~clk_pixel;

  // Symbols are laid end to end on a serial stream, then cut into raw words 'shift' bits early.
  task automatic applyStimulus(input logic [9:0] sym);
    pair     = {sym, lastSym};
    raw_word = pair[(10 - shift) +: 10];
    lastSym  = sym;
    @(posedge clk_pixel);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    seqSym = '{T0, T0, T3, T3, 10'h100, 10'h200, 10'h39C, 10'h0C9,
               10'h0AA, 10'h3AA, 10'h155, 10'h255, T2, T1, 10'h100, T0};
    seqExp = '{11'h000, 11'h000, 11'h300, 11'h300, 11'h700, 11'h7FF, 11'h7A5, 11'h7A5,
               11'h700, 11'h7FF, 11'h7FF, 11'h700, 11'h200, 11'h100, 11'h500, 11'h000};

    reset        = 1'b0;
    raw_word     = 10'h000;
    force_search = 1'b0;
    #12;
    checkOutput("rst_locked", 32'(locked), 32'd0);
    checkOutput("rst_offset", 32'(bit_offset), 32'd0);
    checkOutput("rst_dec", 32'({de, ctrl, data}), 32'd0);
`ifdef TMDS_ALIGN_STATS_EN
    checkOutput("rst_stats", 32'({relock_count, offset_at_lock}), 32'd0);
`endif
    @(posedge clk_pixel);
    #1;
    reset = 1'b1;
    cyc   = 0;

    $display("[TB] search for offset 3");
    while (cyc < 32) applyStimulus(T0);
    checkOutput("search_off0", 32'(bit_offset), 32'd0);
    while (cyc < 96) applyStimulus(T0);
    checkOutput("search_off1", 32'(bit_offset), 32'd1);
    while (cyc < 160) applyStimulus(T0);
    checkOutput("search_off2", 32'(bit_offset), 32'd2);
    while (!locked && cyc < 202) applyStimulus(T0);
    checkOutput("lock3_locked", 32'(locked), 32'd1);
    checkOutput("lock3_offset", 32'(bit_offset), 32'd3);
    checkOutput("lock3_dec", 32'({de, ctrl, data}), 32'd0);
`ifdef TMDS_ALIGN_STATS_EN
    checkOutput("lock3_stat_off", 32'(offset_at_lock), 32'd3);
`endif

    $display("[TB] decode vectors");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(i < 16 ? seqSym[i] : T0);
      if (i >= 2) checkOutput($sformatf("dec%0d", i - 2), 32'({de, ctrl, data}), 32'(seqExp[i - 2]));
    end

    $display("[TB] loss timeout");
    for (int i = 0; i < LOSS - 4; i++) applyStimulus(10'h100);
    checkOutput("timeout_before", 32'(locked), 32'd1);
    for (int i = 0; i < 8; i++) applyStimulus(10'h100);
    checkOutput("timeout_locked", 32'(locked), 32'd0);
    checkOutput("timeout_offset", 32'(bit_offset), 32'd3);
    checkOutput("timeout_dec", 32'({de, ctrl, data}), 32'd0);
`ifdef TMDS_ALIGN_STATS_EN
    checkOutput("timeout_relock", 32'(relock_count), 32'd1);
`endif

    $display("[TB] interrupted token run");
    for (int i = 0; i < 7; i++) applyStimulus(T0);
    applyStimulus(10'h100);
    for (int i = 0; i < 7; i++) applyStimulus(T0);
    checkOutput("interrupt_nolock", 32'(locked), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(T0);
    checkOutput("interrupt_lock", 32'(locked), 32'd1);
    checkOutput("interrupt_offset", 32'(bit_offset), 32'd3);

    $display("[TB] force_search from offset 3, relock at 9");
    force_search = 1'b1;
    applyStimulus(T0);
    force_search = 1'b0;
    checkOutput("force3_offset", 32'(bit_offset), 32'd4);
    shift = 9;
    applyStimulus(T0);
    checkOutput("force3_locked", 32'(locked), 32'd0);
    for (int n = 0; n < 420 && !locked; n++) applyStimulus(T0);
    checkOutput("lock9_locked", 32'(locked), 32'd1);
    checkOutput("lock9_offset", 32'(bit_offset), 32'd9);
    checkOutput("lock9_dec", 32'({de, ctrl, data}), 32'd0);
`ifdef TMDS_ALIGN_STATS_EN
    checkOutput("lock9_stat_off", 32'(offset_at_lock), 32'd9);
`endif
    force_search = 1'b1;
    applyStimulus(T0);
    force_search = 1'b0;
    checkOutput("force9_offset", 32'(bit_offset), 32'd0);
    applyStimulus(T0);
    checkOutput("force9_locked", 32'(locked), 32'd0);
`ifdef TMDS_ALIGN_STATS_EN
    checkOutput("force9_relock", 32'(relock_count), 32'd3);
`endif

    $display("[TB] async reset at offset 5");
    for (int n = 0; n < 400 && bit_offset != 4'd5; n++) applyStimulus(T0);
    checkOutput("reach_off5", 32'(bit_offset), 32'd5);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("midrst_offset", 32'(bit_offset), 32'd0);
    checkOutput("midrst_locked", 32'(locked), 32'd0);
    checkOutput("midrst_dec", 32'({de, ctrl, data}), 32'd0);
`ifdef TMDS_ALIGN_STATS_EN
    checkOutput("midrst_stats", 32'({relock_count, offset_at_lock}), 32'd0);
`endif
    @(posedge clk_pixel);
    #1;
    reset = 1'b1;
    applyStimulus(T0);
    checkOutput("postrst_offset", 32'(bit_offset), 32'd0);
    checkOutput("postrst_locked", 32'(locked), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/tmds_word_aligner.md
Name: tmds_word_aligner

Overview:
- Receive-side counterpart of the TMDS 10:1 output serializer: accepts one raw 10-bit word per pixel clock from the external 1:10 input deserializer primitive.
- Finds the word boundary by searching the 10 possible bit offsets for TMDS control tokens.
- Once locked, performs TMDS 10b→8b / control decode.
- One instance per TMDS channel; feeds the receive video/audio-island logic.

Parameters:
- LOCK_TOKENS, 8: consecutive control tokens at the current offset required to declare lock (range 2..255).
- SEARCH_WINDOW, 4096: cycles spent at one offset before advancing to the next.
- LOSS_TIMEOUT, 65536: cycles without any control token while LOCKED before lock is dropped.

Ports:
- clk_pixel  in  1  pixel clock; sole clock.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- raw_word  in  10  unaligned deserialized word; bit0 = earliest received bit.
- force_search  in  1  single-cycle pulse: drop lock, advance offset, restart search.
- locked  out  1  boundary found and held.
- bit_offset  out  4  current offset candidate, 0..9.
- de  out  1  data-enable (decoded word is pixel/island data, not a control token).
- ctrl  out  2  decoded control bits {C1,C0}; valid when de=0 and locked=1.
- data  out  8  decoded 8-bit data; valid when de=1.

Behaviour:
- Window
  - prev_q holds the previous raw_word.
  - window[19:0] = {raw_word, prev_q}.
  - Candidate word cand = window[bit_offset +: 10].
  - cand is registered into word_q every cycle.
- Token match on word_q, written bit9..bit0:
  - 1101010100 → ctrl 00
  - 0010101011 → ctrl 01
  - 0101010100 → ctrl 10
  - 1010101011 → ctrl 11
- FSM states: SEARCH, LOCKED.
  - Reset state: SEARCH, bit_offset=0, counters=0.
- SEARCH
  - Counters: dwell counts cycles at the current offset; hits counts consecutive tokens.
  - Token: hits+1. Non-token: hits=0.
  - hits reaching LOCK_TOKENS → LOCKED next cycle; bit_offset is kept.
  - dwell reaching SEARCH_WINDOW-1 without lock → bit_offset=(bit_offset+1), wrapping 9→0; dwell=0, hits=0.
  - Lock and dwell expiry in the same cycle: lock wins.
- LOCKED
  - idle counter clears on any token and increments otherwise.
  - idle reaching LOSS_TIMEOUT-1 → SEARCH at the same offset, counters cleared.
- force_search
  - In any state, the next state is SEARCH with bit_offset advanced by 1 (wrap 9→0) and counters cleared.
  - Takes priority over lock acquisition and timeout.
- Decode (registered from word_q)
  - Token: de=0, ctrl=token value, data=0.
  - Otherwise de=1, ctrl holds its previous value, and:
    - q = word_q[9] ? ~word_q[7:0] : word_q[7:0]
    - data[0] = q[0]
    - data[i] = word_q[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]) for i=1..7
- Latency: raw_word presented at edge N produces decoded outputs after edge N+2 (2 cycles).
- While locked=0: de=0, ctrl=00, data=00, regardless of decode.
- locked rises the cycle after the FSM enters LOCKED and falls the cycle after it leaves.
- Reset values: locked=0, bit_offset=0, de=0, ctrl=00, data=00.
- Reset mid-operation clears everything immediately (asynchronous); on release, search restarts at offset 0.
- Counters are sized from their parameters and never wrap.

Optional Feature:
- Macro: TMDS_ALIGN_STATS_EN.
- When defined:
  - Adds output relock_count [15:0], reset 0.
  - Increments on every LOCKED→SEARCH transition (timeout or force_search); saturates at 16'hFFFF.
  - Adds output offset_at_lock [3:0], reset 0, loaded with bit_offset on each SEARCH→LOCKED transition.
- When undefined: neither port exists and no stats logic is built.

Test Plan:
- Serial stream of repeated token 1101010100 shifted by 3 bits, LOCK_TOKENS=8, SEARCH_WINDOW=64 → bit_offset steps 0,1,2,3 every 64 cycles; locked=1 within 64*3+8+2 cycles; bit_offset=3; ctrl=00, de=0.
- After lock at offset 3, send data words encoding 0x00, 0xFF, 0xA5 (bit8/bit9 variants, all four combinations) → data matches 2 cycles later with de=1.
- Locked stream, then 65536 cycles of non-token data → locked falls at cycle LOSS_TIMEOUT+1; bit_offset unchanged; relock_count=1 with TMDS_ALIGN_STATS_EN.
- force_search pulsed while locked at offset 9 → locked=0 next cycle, bit_offset=0, SEARCH restarts.
- Tokens interrupted by one data word after 7 hits → hits clears, no lock until 8 further consecutive tokens.
- Assert reset low mid-search at offset 5 → all outputs at reset values immediately; after release, bit_offset=0.
